// File: rtl/seg_scan_ctrl.sv
// Three-digit multiplexed 7-segment scan controller: drives each digit for CLK_DIV
// cycles, then darkens all anodes for BLANK_CYCLES so the segment mux can settle.
module seg_scan_ctrl #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [2:0] blank_mask,
  output logic [1:0] select,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST =
    (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       sel_nxt;
  logic [3:0]       an_nxt;
  logic             fd_nxt;
  logic             show_last, blank_last;

  assign show_last  = (cnt == SHOW_LAST);
  assign blank_last = (cnt == BLANK_LAST);

  // State, counter and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the values present before the edge, independent of order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      select     <= 2'd0;
      an         <= 4'b1111;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      select     <= sel_nxt;
      an         <= an_nxt;
      frame_done <= fd_nxt;
    end
  end

  // Next-state logic; a low en overrides any terminal-count transition.
  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = select;
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      sel_nxt   = 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
          sel_nxt   = 2'd0;
        end
        SHOW: begin
          if (show_last) begin
            cnt_nxt   = '0;
            sel_nxt   = (select == 2'd2) ? 2'd0 : select + 2'd1;
            state_nxt = (BLANK_CYCLES > 0) ? BLANK : SHOW;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        BLANK: begin
          if (blank_last) begin
            cnt_nxt   = '0;
            state_nxt = SHOW;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          sel_nxt   = 2'd0;
        end
      endcase
    end
  end

  // Output logic: anodes are decoded from the upcoming state and digit so the
  // registered an lines up cycle-for-cycle with state and select.
  always_comb begin
    an_nxt = 4'b1111;
    fd_nxt = en && (state == SHOW) && show_last && (select == 2'd2);
    if (state_nxt == SHOW) begin
      for (int i = 0; i < 3; i++) begin
        if (sel_nxt == 2'(i) && !blank_mask[i]) an_nxt[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a CLK_DIV=4/BLANK_CYCLES=2 instance and a degenerate
// CLK_DIV=1/BLANK_CYCLES=0 instance share stimulus and are checked against a timeline model.
module tb_seg_scan_ctrl;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [2:0] blank_mask;
  logic [1:0] sel_a, sel_b;
  logic [3:0] an_a, an_b;
  logic       fd_a, fd_b;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan_ctrl #(.CLK_DIV(4), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .blank_mask(blank_mask),
    .select(sel_a), .an(an_a), .frame_done(fd_a)
  );

  seg_scan_ctrl #(.CLK_DIV(1), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en), .blank_mask(blank_mask),
    .select(sel_b), .an(an_b), .frame_done(fd_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: t counts cycles since the scan (re)started at digit 0.
  bit         act_a = 1'b0, act_b = 1'b0;
  int         t_a = 0, t_b = 0;
  logic [2:0] mask_q = 3'b000;

  function automatic logic [6:0] model_out(input bit act, input int t, input logic [2:0] m,
                                           input int cdiv, input int blk);
    int p, d, r;
    logic [1:0] s;
    logic [3:0] a;
    logic f;
    if (!act) return {1'b0, 2'd0, 4'b1111};
    p = cdiv + blk;
    d = (t / p) % 3;
    r = t % p;
    a = 4'b1111;
    if (r < cdiv) begin
      s = 2'(d);
      if (!m[d]) a[d] = 1'b0;
    end else begin
      s = 2'((d + 1) % 3);
    end
    f = (t >= 2 * p + cdiv) && (((t - 2 * p - cdiv) % (3 * p)) == 0);
    return {f, s, a};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_a = 1'b0; t_a = 0;
      act_b = 1'b0; t_b = 0;
    end else begin
      if (!en) begin
        act_a = 1'b0; t_a = 0;
        act_b = 1'b0; t_b = 0;
      end else if (!act_a) begin
        act_a = 1'b1; t_a = 0;
        act_b = 1'b1; t_b = 0;
      end else begin
        t_a++;
        t_b++;
      end
      mask_q = blank_mask;
    end
  end

  always @(negedge clk) begin
    logic [6:0] ea, eb;
    ea = model_out(act_a, t_a, mask_q, 4, 2);
    eb = model_out(act_b, t_b, mask_q, 1, 0);
    check("model_a_an",  32'(an_a),  32'(ea[3:0]));
    check("model_a_sel", 32'(sel_a), 32'(ea[5:4]));
    check("model_a_fd",  32'(fd_a),  32'(ea[6]));
    check("model_b_an",  32'(an_b),  32'(eb[3:0]));
    check("model_b_sel", 32'(sel_b), 32'(eb[5:4]));
    check("model_b_fd",  32'(fd_b),  32'(eb[6]));
  end

  // Hand-written first frame after a (re)start, for both instances.
  logic [3:0] lit_an_a  [18] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF,
                                 4'hD, 4'hD, 4'hD, 4'hD, 4'hF, 4'hF,
                                 4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'hF};
  logic [1:0] lit_sel_a [18] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1,
                                 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2,
                                 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
  logic [3:0] lit_an_b  [3]  = '{4'hE, 4'hD, 4'hB};

  task automatic literal_frame(input string tag);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check({tag, "_an_a"},  32'(an_a),  32'(lit_an_a[i]));
      check({tag, "_sel_a"}, 32'(sel_a), 32'(lit_sel_a[i]));
      check({tag, "_fd_a"},  32'(fd_a),  (i == 16) ? 32'd1 : 32'd0);
      check({tag, "_an_b"},  32'(an_b),  32'(lit_an_b[i % 3]));
      check({tag, "_sel_b"}, 32'(sel_b), 32'(i % 3));
      check({tag, "_fd_b"},  32'(fd_b),  (i > 0 && i % 3 == 0) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(act_a && (t_a % 18) == ph) && n < 100);
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_phase_%0d: timed out after %0d cycles", ph, n);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    en         = 1'b0;
    blank_mask = 3'b000;
    repeat (3) @(negedge clk);
    check("reset_an",  32'(an_a),  32'hF);
    check("reset_sel", 32'(sel_a), 32'd0);
    check("reset_fd",  32'(fd_a),  32'd0);

    // Release with en already high: first SHOW cycle follows the next edge.
    reset_n = 1'b1;
    en      = 1'b1;
    literal_frame("scan");
    @(negedge clk);
    check("scan_wrap_an", 32'(an_a), 32'hE);

    // Digit 2 suppressed: slot stays dark but select and frame_done continue.
    blank_mask = 3'b100;
    wait_phase(12);
    check("mask_an_d2",  32'(an_a),  32'hF);
    check("mask_sel_d2", 32'(sel_a), 32'd2);
    wait_phase(16);
    check("mask_fd", 32'(fd_a), 32'd1);
    blank_mask = 3'b000;

    // One-cycle disable in the middle of digit 1's SHOW.
    wait_phase(7);
    en = 1'b0;
    @(negedge clk);
    check("dis_an",  32'(an_a),  32'hF);
    check("dis_sel", 32'(sel_a), 32'd0);
    check("dis_fd",  32'(fd_a),  32'd0);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("resume_show_an", 32'(an_a), 32'hE);
      check("resume_sel",     32'(sel_a), 32'd0);
    end
    @(negedge clk);
    check("resume_blank_an",  32'(an_a),  32'hF);
    check("resume_blank_sel", 32'(sel_a), 32'd1);

    // Asynchronous reset between edges in the first BLANK cycle.
    wait_phase(4);
    #2 reset_n = 1'b0;
    #1;
    check("areset_an",   32'(an_a),  32'hF);
    check("areset_sel",  32'(sel_a), 32'd0);
    check("areset_fd",   32'(fd_a),  32'd0);
    check("areset_an_b", 32'(an_b),  32'hF);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    literal_frame("post_reset");

    // All digits masked: timing and frame_done unchanged, anodes dark.
    blank_mask = 3'b111;
    wait_phase(8);
    check("mask_all_an",  32'(an_a),  32'hF);
    check("mask_all_sel", 32'(sel_a), 32'd1);
    wait_phase(16);
    check("mask_all_fd",   32'(fd_a), 32'd1);
    check("mask_all_an_b", 32'(an_b), 32'hF);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
